data_ram_ctrl: RTL and testbench

//   Parametrised word-organised data RAM with a valid/ready request port, byte-lane

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_byte_array.sv | 53 +++++
 rtl/data_ram_ctrl.sv | 157 +++++++++++++++
 tb/tb_data_ram_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and index helpers for the data RAM controller.
// Build option: DATA_RAM_CLEAR_EN selects the post-reset clear sequencer.
package ram_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_ALIGN    = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_e;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    // Byte-offset bits inside one word (shift from byte offset to word index).
    function automatic int unsigned lane_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word-index width; never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// DEPTH x DATA_W storage with per-lane write enables and a registered read port.
module ram_byte_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = idx_bits(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Byte-lane writes; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read data holds unless a read is issued.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Word-organised data RAM controller: window decode, error reporting, responses.
// Build option: DATA_RAM_CLEAR_EN zeroes the array after every reset release.
module data_ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 32'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  r,
    input  logic                  w,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     mem_in,
    output logic [DATA_W-1:0]     mem_out,
    output logic                  rsp_valid,
    output logic [1:0]            err
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned LANE_SH = lane_shift(DATA_W);
    localparam int unsigned IDX_W   = idx_bits(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SPAN_A  = ADDR_W'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(BYTES - 1);

    logic [ADDR_W-1:0] off_c;
    logic [IDX_W-1:0]  idx_c;
    err_e              dec_err_c;
    logic              accept_c;
    logic              rd_en_c;
    logic [BYTES-1:0]  arr_be_c;
    logic [IDX_W-1:0]  arr_idx_c;
    logic [DATA_W-1:0] arr_wdata_c;

    logic clr_we_c;
    logic [IDX_W-1:0] clr_idx_c;
    logic ready_en_c;

    logic rsp_valid_q, rsp_valid_d;
    err_e err_q, err_d;
    logic req_ready_q, req_ready_d;

    // Address window decode and error priority: conflict, range, alignment.
    always_comb begin
        off_c     = address - BASE_A;
        idx_c     = IDX_W'(off_c >> LANE_SH);
        dec_err_c = ERR_NONE;
        if (r && w) begin
            dec_err_c = ERR_CONFLICT;
        end else if ((address < BASE_A) || (off_c >= SPAN_A)) begin
            dec_err_c = ERR_RANGE;
        end else if ((off_c & ALIGN_M) != '0) begin
            dec_err_c = ERR_ALIGN;
        end
    end

`ifdef DATA_RAM_CLEAR_EN
    state_e state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    // Clear sequencer: one zero word per cycle, then hand over to IDLE.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we_c  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we_c  = rst;
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase
        clr_idx_c  = clr_idx_q;
        ready_en_c = (state_d == S_IDLE);
    end

    // Sequencer state; reset always restarts the clear from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end
`else
    // No clear pass: ready as soon as reset is released.
    always_comb begin
        clr_we_c   = 1'b0;
        clr_idx_c  = '0;
        ready_en_c = 1'b1;
    end
`endif

    // Accept, response next state and array port steering.
    always_comb begin
        accept_c    = req_valid && req_ready_q && rst;
        rsp_valid_d = accept_c;
        err_d       = accept_c ? dec_err_c : err_q;
        req_ready_d = ready_en_c;
        rd_en_c     = accept_c && (dec_err_c == ERR_NONE) && r && !w;
        arr_be_c    = '0;
        arr_idx_c   = idx_c;
        arr_wdata_c = mem_in;
        if (clr_we_c) begin
            arr_be_c    = '1;
            arr_idx_c   = clr_idx_c;
            arr_wdata_c = '0;
        end else if (accept_c && (dec_err_c == ERR_NONE) && w && !r) begin
            arr_be_c = be;
        end
    end

    // Response and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            err_q       <= ERR_NONE;
            req_ready_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
        end
    end

    ram_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_be   (arr_be_c),
        .wr_idx  (arr_idx_c),
        .wr_data (arr_wdata_c),
        .rd_en   (rd_en_c),
        .rd_idx  (idx_c),
        .rd_data (mem_out)
    );

    assign rsp_valid = rsp_valid_q;
    assign err       = 2'(err_q);
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Randomised self-checking bench for data_ram_ctrl against a byte-level model.
// Build option: DATA_RAM_CLEAR_EN enables the clear-sequence checks.
module tb_data_ram_ctrl;
    import ram_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam int unsigned SPAN   = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        r;
    logic        w;
    logic [31:0] address;
    logic [3:0]  be;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        rsp_valid;
    logic [1:0]  err;

    data_ram_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .r         (r),
        .w         (w),
        .address   (address),
        .be        (be),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .rsp_valid (rsp_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: byte image of the window plus a known-byte mask.
    logic [7:0]  mb [SPAN];
    bit          mv [SPAN];
    logic [31:0] exp_mo;
    bit          exp_known;
    logic [1:0]  exp_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input bit rr, input bit ww, input logic [31:0] a);
        if (rr && ww) return ERR_CONFLICT;
        if (a < BASE || (a - BASE) >= SPAN) return ERR_RANGE;
        if (a % 4 != 0) return ERR_ALIGN;
        return ERR_NONE;
    endfunction

    // One request cycle, driven at a falling edge and checked at the next one.
    task automatic step(input bit v, input bit rr, input bit ww, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input string tag);
        bit acc;
        logic [1:0] e;
        int off;
        req_valid = v; r = rr; w = ww; address = a; be = b; mem_in = d;
        acc = v && (req_ready === 1'b1);
        e = model_err(rr, ww, a);
        if (acc) begin
            exp_err = e;
            if (e == ERR_NONE) begin
                off = int'(a - BASE);
                if (ww && !rr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) begin
                            mb[off+i] = d[8*i +: 8];
                            mv[off+i] = 1'b1;
                        end
                    end
                end
                if (rr && !ww) begin
                    exp_known = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        exp_mo[8*i +: 8] = mb[off+i];
                        exp_known = exp_known && mv[off+i];
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rsp"}, 32'(rsp_valid), 32'(acc));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
        if (exp_known) chk({tag, ".dout"}, mem_out, exp_mo);
    endtask

    // One-cycle reset (request optionally present), then wait for ready.
    task automatic do_reset(input bit v_during, input string tag);
        int n;
        rst = 1'b0; req_valid = v_during; r = 1'b1; w = 1'b0; address = BASE; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rsp"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".dout"}, mem_out, 32'd0);
        chk({tag, ".rdy"}, 32'(req_ready), 32'd0);
        exp_mo = '0; exp_known = 1'b1; exp_err = ERR_NONE;
        rst = 1'b1; req_valid = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
        n = 0;
        while (req_ready !== 1'b1 && n < 3000) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, ".clrcyc"}, 32'(n), 32'd1024);
        for (int i = 0; i < SPAN; i++) begin
            mb[i] = 8'h00;
            mv[i] = 1'b1;
        end
`else
        n = 0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rel_rdy"}, 32'(req_ready), 32'd1);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int k, op;
        bit v, rr, ww;
        rst = 1'b0; req_valid = 1'b0; r = 1'b0; w = 1'b0;
        address = '0; be = '0; mem_in = '0;
        exp_mo = '0; exp_known = 1'b0; exp_err = ERR_NONE;
        for (int i = 0; i < SPAN; i++) mv[i] = 1'b0;

        do_reset(1'b0, "init");

`ifdef DATA_RAM_CLEAR_EN
        // Dirty a word, then reset in the middle of the clear and expect a full pass.
        step(1, 0, 1, 32'h1000, 4'hF, 32'hCAFEF00D, "dirty");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (499) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid.rdy", 32'(req_ready), 32'd0);
        do_reset(1'b0, "midclr");
        step(1, 1, 0, 32'h1000, 4'h0, 32'h0, "clr_rd");
        chk("clr_rd.zero", mem_out, 32'h0);
`endif

        // Basic full-word writes and read-back.
        step(1, 0, 1, 32'h1000, 4'hF, 32'h13FF, "t1w0");
        step(1, 0, 1, 32'h1004, 4'hF, 32'h100, "t1w1");
        step(1, 1, 0, 32'h1000, 4'h0, 32'h0, "t1r0");
        chk("t1.d0", mem_out, 32'h13FF);
        step(1, 1, 0, 32'h1004, 4'h0, 32'h0, "t1r1");
        chk("t1.d1", mem_out, 32'h100);
        step(0, 0, 0, 32'h0, 4'h0, 32'h0, "t1idle");

        // Partial byte-lane write.
        step(1, 0, 1, 32'h1008, 4'hF, 32'hAABBCCDD, "t2w0");
        step(1, 0, 1, 32'h1008, 4'b0101, 32'h11223344, "t2w1");
        step(1, 1, 0, 32'h1008, 4'h0, 32'h0, "t2r");
        chk("t2.merge", mem_out, 32'hAA22CC44);

        // Window edges, alignment and conflict; mem_out holds on errors.
        step(1, 0, 1, 32'h1FFC, 4'hF, 32'hDEADBEEF, "t3wtop");
        step(1, 1, 0, 32'h0FFC, 4'h0, 32'h0, "t3below");
        chk("t3.below_err", 32'(err), 32'(ERR_RANGE));
        step(1, 1, 0, 32'h1FFC, 4'h0, 32'h0, "t3top");
        chk("t3.top_data", mem_out, 32'hDEADBEEF);
        step(1, 1, 0, 32'h2000, 4'h0, 32'h0, "t3above");
        chk("t3.above_err", 32'(err), 32'(ERR_RANGE));
        step(1, 1, 0, 32'h1002, 4'h0, 32'h0, "t3align");
        chk("t3.align_err", 32'(err), 32'(ERR_ALIGN));
        step(1, 1, 1, 32'h1000, 4'hF, 32'h55555555, "t3conf");
        chk("t3.conf_err", 32'(err), 32'(ERR_CONFLICT));
        chk("t3.held", mem_out, 32'hDEADBEEF);
        step(1, 1, 0, 32'h1000, 4'h0, 32'h0, "t3chk");
        chk("t3.unchanged", mem_out, 32'h13FF);

        // Zero-lane write and no-op request still respond.
        step(1, 0, 1, 32'h1000, 4'h0, 32'hFFFFFFFF, "t3be0");
        step(1, 0, 0, 32'h1000, 4'h0, 32'h0, "t3nop");

        // Back-to-back write then read of the same word.
        step(1, 0, 1, 32'h100C, 4'hF, 32'h5, "t4w");
        step(1, 1, 0, 32'h100C, 4'h0, 32'h0, "t4r");
        chk("t4.fwd", mem_out, 32'h5);

        // Reset mid-stream with a request pending.
        do_reset(1'b1, "t5rst");
        step(1, 1, 0, 32'h1008, 4'h0, 32'h0, "t5r");

        // Randomised traffic concentrated on a small set of words.
        for (int it = 0; it < 600; it++) begin
            k = $urandom_range(0, 19);
            if (k < 14)       a = BASE + 4 * $urandom_range(0, 15);
            else if (k == 14) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else if (k == 15) a = BASE - 4 * $urandom_range(1, 4);
            else if (k == 16) a = BASE + SPAN + 4 * $urandom_range(0, 3);
            else if (k == 17) a = BASE + SPAN - 4;
            else              a = $urandom;
            op = $urandom_range(0, 9);
            rr = (op < 4) || (op == 8);
            ww = (op >= 4 && op < 9);
            v  = ($urandom_range(0, 4) != 0);
            step(v, rr, ww, a, 4'($urandom), $urandom, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
